core_step_ctrl: RTL and testbench
=================================

// Module: core_step_ctrl
// PURPOSE
//  Run/halt/single-step sequencer for the RISC-V core. Sits in top between board
//  switches/button and Core; drives the core clock-enable, replacing a derived
//  slow clock. Modes: halted, free-run at full rate, free-run at divided rate,
//  one instruction per button press. A halt request from the core locks it stopped.
// PARAMETERS
//  DIV         100000   core_en period (cycles) in divided run mode; >=2
//  DEB_CYCLES  1000000  cycles step_btn must be stable before a level is accepted; >=1
//  CNT_W       32       width of step_cnt
// PORTS
//  clk       in   1      system clock
//  rst       in   1      synchronous reset, active-high
//  run_sw    in   1      async level: 1=run, 0=halt/step mode
//  fast_sw   in   1      async level: 1=core_en every cycle in RUN, 0=once per DIV cycles
//  step_btn  in   1      async raw push button (bouncy), 1=pressed
//  halt_req  in   1      sync from core (e.g. ebreak); 1-cycle pulse or level
//  core_en   out  1      clock-enable to core; core advances one cycle per high cycle
//  halted    out  1      1 when state is HALT or LOCK
//  step_cnt  out  CNT_W  count of cycles with core_en=1
// BEHAVIOUR
//  - Reset: state=HALT, core_en=0, halted=1, step_cnt=0, divider=0, synchronizers=0,
//    debounced btn=0, debounce counter=0. Reset mid-operation aborts immediately
//    (no pending step or tick survives).
//  - run_sw, fast_sw, step_btn: each through a 2-flop synchronizer (run_s, fast_s, btn_s).
//  - Debounce: counter reset to 0 whenever btn_s == btn_db; else increments.
//    When it reaches DEB_CYCLES-1 while btn_s != btn_db: btn_db <= btn_s, counter <= 0.
//    press = 1-cycle pulse on btn_db 0->1.
//  - FSM states HALT, RUN, STEP, LOCK:
//    HALT: run_s=1 -> RUN; else press -> STEP; else stay.
//    STEP: exactly one cycle; -> RUN if run_s=1, else -> HALT.
//    RUN : run_s=0 -> HALT; else halt_req=1 -> LOCK; else stay.
//    LOCK: run_s=0 -> HALT; else stay. Press ignored.
//    run_s=0 has priority over halt_req in RUN.
//  - core_en = STEP | (RUN & ~halt_req & (fast_s | tick)). halt_req is the only
//    combinational input path; in STEP, halt_req is ignored (the step still issues).
//  - Divider: counts 0..DIV-1 only when state=RUN and fast_s=0;
//    tick = (count==DIV-1), then wraps to 0. Forced to 0 when not RUN or fast_s=1.
//    First divided core_en comes DIV cycles after entering RUN. A tick suppressed
//    by halt_req is lost.
//  - Press while RUN, LOCK or STEP is discarded (not queued).
//  - halted registered-equivalent: decoded from state only.
//  - step_cnt += 1 on every cycle core_en=1; wraps modulo 2^CNT_W.
//  - Latency: run_sw sampled high at edge k -> run_s=1 after edge k+1 -> state=RUN
//    after edge k+2 -> core_en=1 (fast) in that cycle. Button edge to STEP:
//    2 sync + DEB_CYCLES + 1 cycles.
// TESTING (DIV=4, DEB_CYCLES=3)
//  1. Reset 5 cycles, all inputs 0 -> core_en=0, halted=1, step_cnt=0 throughout.
//  2. run_sw=1, fast_sw=1 -> core_en high continuously from 3rd cycle after edge;
//     after 10 cycles step_cnt=10; run_sw=0 -> core_en=0, halted=1 three cycles later.
//  3. run_sw=1, fast_sw=0 for 20 cycles in RUN -> core_en pulses every 4th cycle,
//     first pulse 4 cycles after RUN entry, step_cnt=5.
//  4. Halted; step_btn bounces 1/0/1 in 1-cycle chunks then holds 1 for 6 cycles
//     -> exactly one core_en pulse, step_cnt=1; release and re-press -> step_cnt=2.
//  5. RUN fast, halt_req pulse 1 cycle -> core_en=0 that cycle, LOCK, halted=1;
//     button press ignored; run_sw 0 then 1 -> RUN resumes.
//  6. step_cnt preloaded near wrap (force 32'hFFFF_FFFF) + one step -> 0; rst asserted
//     during divided RUN at count=2 -> next cycle state HALT, divider 0, core_en=0.

Source files
------------

// File: rtl/core_step_ctrl.sv
// core_step_ctrl: run/halt/single-step sequencer driving the core clock-enable
module core_step_ctrl #(
  parameter int DIV        = 100000,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             fast_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             core_en,
  output logic             halted,
  output logic [CNT_W-1:0] step_cnt
);
  localparam int DVW = $clog2(DIV);
  localparam int DBW = $clog2(DEB_CYCLES + 1);
  typedef enum logic [1:0] {HALT, RUN, STEP, LOCK} state_t;
  state_t state, state_nx;
  logic run_m, run_s, fast_m, fast_s, btn_m, btn_s, btn_db, press, deb_hit, tick;
  logic [DBW-1:0] deb_cnt;
  logic [DVW-1:0] div_cnt;
  assign deb_hit = btn_s != btn_db && deb_cnt == DBW'(DEB_CYCLES - 1);
  assign tick    = state == RUN && !fast_s && div_cnt == DVW'(DIV - 1);
  // Synchronize switches/button and debounce the button into a press pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      {run_m, run_s, fast_m, fast_s, btn_m, btn_s} <= '0;
      btn_db  <= 1'b0;
      press   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      {run_s, run_m}   <= {run_m, run_sw};
      {fast_s, fast_m} <= {fast_m, fast_sw};
      {btn_s, btn_m}   <= {btn_m, step_btn};
      deb_cnt <= (btn_s == btn_db || deb_hit) ? '0 : deb_cnt + DBW'(1);
      btn_db  <= deb_hit ? btn_s : btn_db;
      press   <= deb_hit & btn_s;
    end
  end
  // Rate divider runs only in divided RUN; any other condition parks it at zero
  always_ff @(posedge clk) begin
    if (rst || state != RUN || fast_s || tick) div_cnt <= '0;
    else div_cnt <= div_cnt + DVW'(1);
  end
  // State register and count of enabled core cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HALT;
      step_cnt <= '0;
    end else begin
      state    <= state_nx;
      step_cnt <= step_cnt + CNT_W'(core_en);
    end
  end
  // Next state and outputs; a step always issues, halt_req only gates RUN
  always_comb begin
    state_nx = state;
    case (state)
      HALT:    state_nx = run_s ? RUN : press ? STEP : HALT;
      RUN:     state_nx = !run_s ? HALT : halt_req ? LOCK : RUN;
      STEP:    state_nx = run_s ? RUN : HALT;
      LOCK:    state_nx = run_s ? LOCK : HALT;
      default: state_nx = HALT;
    endcase
    core_en = state == STEP || (state == RUN && !halt_req && (fast_s || tick));
    halted  = state == HALT || state == LOCK;
  end
endmodule

// File: tb/tb_core_step_ctrl.sv
// tb_core_step_ctrl: scoreboard bench comparing the sequencer against a behavioural model
module tb_core_step_ctrl;
  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam int CW  = 8;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_LOCK = 3;
  typedef struct {
    logic          en;
    logic          hl;
    logic [CW-1:0] cnt;
    int            ph;
  } exp_t;
  logic clk = 0, rst = 1, run_sw = 0, fast_sw = 0, step_btn = 0, halt_req = 0;
  logic core_en, halted;
  logic [CW-1:0] step_cnt;
  exp_t q[$];
  int total = 0, passed = 0, phase = 0;
  bit valid = 0;
  int m_r1, m_rs, m_f1, m_fs, m_b1, m_bs, m_db, m_press, m_stable, m_mode, m_phase, m_cnt;

  core_step_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .fast_sw(fast_sw), .step_btn(step_btn),
    .halt_req(halt_req), .core_en(core_en), .halted(halted), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  function automatic int exp_en(input int h);
    if (m_mode == M_STEP) return 1;
    if (m_mode != M_RUN || h != 0) return 0;
    return (m_fs != 0 || (m_phase % DIV) == DIV - 1) ? 1 : 0;
  endfunction

  task automatic model_update(input int r, input int rs, input int fs, input int b, input int h);
    int en, nm, np;
    if (r != 0) begin
      {m_r1, m_rs, m_f1, m_fs, m_b1, m_bs} = '0;
      m_db = 0; m_press = 0; m_stable = 0; m_mode = M_HALT; m_phase = 0; m_cnt = 0;
      return;
    end
    en = exp_en(h);
    nm = m_mode;
    if (m_mode == M_HALT) nm = m_rs != 0 ? M_RUN : (m_press != 0 ? M_STEP : M_HALT);
    else if (m_mode == M_STEP) nm = m_rs != 0 ? M_RUN : M_HALT;
    else if (m_mode == M_RUN) nm = m_rs == 0 ? M_HALT : (h != 0 ? M_LOCK : M_RUN);
    else nm = m_rs == 0 ? M_HALT : M_LOCK;
    m_cnt = (m_cnt + en) % (1 << CW);
    m_phase = (m_mode == M_RUN && m_fs == 0) ? m_phase + 1 : 0;
    np = 0;
    if (m_bs != m_db) begin
      m_stable++;
      if (m_stable == DEB) begin
        m_db = m_bs;
        m_stable = 0;
        np = m_db;
      end
    end else m_stable = 0;
    m_mode = nm;
    m_press = np;
    m_rs = m_r1; m_r1 = rs;
    m_fs = m_f1; m_f1 = fs;
    m_bs = m_b1; m_b1 = b;
  endtask

  task automatic cyc(input int r, input int rs, input int fs, input int b, input int h);
    exp_t e;
    rst = r[0]; run_sw = rs[0]; fast_sw = fs[0]; step_btn = b[0]; halt_req = h[0];
    if (valid) begin
      e.en  = exp_en(h) != 0;
      e.hl  = (m_mode == M_HALT || m_mode == M_LOCK);
      e.cnt = CW'(m_cnt);
      e.ph  = phase;
      q.push_back(e);
    end
    @(posedge clk);
    model_update(r, rs, fs, b, h);
    if (r != 0) valid = 1;
    #1;
  endtask

  task automatic rep(input int n, input int r, input int rs, input int fs, input int b, input int h);
    for (int i = 0; i < n; i++) cyc(r, rs, fs, b, h);
  endtask

  // Monitor: pop one expectation per cycle and compare on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({core_en, halted, step_cnt} !== {e.en, e.hl, e.cnt})
          $display("FAIL ph%0d outputs: got en=%b halted=%b cnt=%0d, expected en=%b halted=%b cnt=%0d",
                   e.ph, core_en, halted, step_cnt, e.en, e.hl, e.cnt);
        else passed++;
      end
    end
  end

  initial begin
    int rs, fs, b, h, r;
    #1;
    phase = 1; rep(5, 1, 0, 0, 0, 0); rep(3, 0, 0, 0, 0, 0);
    phase = 2; rep(13, 0, 1, 1, 0, 0); rep(5, 0, 0, 1, 0, 0);
    phase = 3; rep(23, 0, 1, 0, 0, 0); rep(5, 0, 0, 0, 0, 0);
    phase = 4; cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0);
    rep(6, 0, 0, 0, 1, 0); rep(8, 0, 0, 0, 0, 0); rep(8, 0, 0, 0, 1, 0); rep(8, 0, 0, 0, 0, 0);
    phase = 5; rep(6, 0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 1); rep(4, 0, 1, 1, 0, 0);
    rep(8, 0, 1, 1, 1, 0); rep(8, 0, 1, 1, 0, 0); rep(3, 0, 0, 1, 0, 0);
    rep(6, 0, 1, 1, 0, 0); rep(5, 0, 0, 1, 0, 0);
    phase = 6; rep(260, 0, 1, 1, 0, 0); rep(5, 0, 0, 1, 0, 0);
    rep(8, 0, 0, 0, 1, 0); rep(8, 0, 0, 0, 0, 0);
    rep(5, 0, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); rep(3, 0, 0, 0, 0, 0);
    rep(12, 0, 1, 0, 0, 0); rep(4, 0, 0, 0, 0, 0);
    phase = 7; rs = 0; fs = 0; b = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) rs = 1 - rs;
      if ($urandom_range(29) == 0) fs = 1 - fs;
      if ($urandom_range(5) == 0) b = 1 - b;
      h = ($urandom_range(19) == 0) ? 1 : 0;
      r = ($urandom_range(299) == 0) ? 1 : 0;
      cyc(r, rs, fs, b, h);
    end
    rep(3, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    total++;
    if (q.size() != 0) $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
